// File: rtl/arb4_ctrl_pkg.sv
// Shared constants and state type for the 4-requester arbiter.
// State encoding, requester count/id width and arbitration mode values.
package arb4_ctrl_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } state_t;

endpackage

// File: rtl/arb4_ctrl_prio4.sv
// Combinational rotated 4-to-2 priority encoder.
// Fixed mode behaves as round-robin with the pointer forced to 0 (order 3 > 2 > 1 > 0).
module arb_prio4
  import arb4_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            mode,
  output logic [ID_W-1:0] win_id,
  output logic            win_valid
);

  logic [ID_W-1:0] base;
  logic [NREQ-1:0] rot;
  logic [ID_W-1:0] rank;

  always_comb begin
    base = (mode == MODE_FIXED) ? '0 : ptr;
    rot  = '0;
    // rot[3] is the highest-priority requester (base-1), rot[0] the last grantee.
    for (int m = 0; m < NREQ; m++) begin
      rot[NREQ-1-m] = req[base - ID_W'(m) - ID_W'(1)];
    end

    rank = '0;
    casez (rot)
      4'b1???: rank = 2'd0;
      4'b01??: rank = 2'd1;
      4'b001?: rank = 2'd2;
      4'b0001: rank = 2'd3;
      default: rank = 2'd0;
    endcase

    win_valid = |req;
    win_id    = base - rank - ID_W'(1);
  end

endmodule

// File: rtl/arb4_ctrl.sv
// Arbiter FSM: registers the winner, enforces the hold limit, inserts one idle cycle between grants.
// All outputs are registered; expire is a one-cycle pulse in the idle cycle after a forced release.
module arb4_ctrl
  import arb4_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            mode,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            valid,
  output logic            expire
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t            state, nxt_state;
  logic [HOLD_W-1:0] hold_cnt, nxt_hold;
  logic [ID_W-1:0]   ptr, nxt_ptr;
  logic [NREQ-1:0]   nxt_gnt;
  logic [ID_W-1:0]   nxt_gnt_id;
  logic              nxt_expire;
  logic [ID_W-1:0]   win_id;
  logic              win_valid;

  arb_prio4 u_prio (
    .req       (req),
    .ptr       (ptr),
    .mode      (mode),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    nxt_state  = state;
    nxt_gnt    = gnt;
    nxt_gnt_id = gnt_id;
    nxt_hold   = hold_cnt;
    nxt_ptr    = ptr;
    nxt_expire = 1'b0;

    case (state)
      S_IDLE: begin
        if (win_valid) begin
          nxt_state  = S_GRANT;
          nxt_gnt    = NREQ'(1) << win_id;
          nxt_gnt_id = win_id;
          nxt_hold   = '0;
          nxt_ptr    = win_id;
        end
      end
      S_GRANT: begin
        // Only the current grantee's request bit matters during a tenure.
        if (!req[gnt_id]) begin
          nxt_state  = S_IDLE;
          nxt_gnt    = '0;
          nxt_gnt_id = '0;
        end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
          nxt_state  = S_IDLE;
          nxt_gnt    = '0;
          nxt_gnt_id = '0;
          nxt_expire = 1'b1;
        end else if (hold_cnt != '1) begin
          nxt_hold = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        nxt_state  = S_IDLE;
        nxt_gnt    = '0;
        nxt_gnt_id = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      hold_cnt <= '0;
      ptr      <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      valid    <= 1'b0;
      expire   <= 1'b0;
    end else begin
      state    <= nxt_state;
      hold_cnt <= nxt_hold;
      ptr      <= nxt_ptr;
      gnt      <= nxt_gnt;
      gnt_id   <= nxt_gnt_id;
      valid    <= |nxt_gnt;
      expire   <= nxt_expire;
    end
  end

endmodule

// File: tb/tb_arb4_ctrl.sv
// Three arbiters (hold limits 2, 8, unlimited) share stimulus and are checked every cycle
// against a tenure-counting reference model, plus directed scenario checks.
module tb_arb4_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;

  logic [3:0] gnt_o [3];
  logic [1:0] id_o  [3];
  logic       vld_o [3];
  logic       exp_o [3];

  localparam int MH [3] = '{2, 8, 0};

  int n_cmp = 0;
  int n_err = 0;

  arb4_ctrl #(.MAX_HOLD(2), .HOLD_W(4)) u_h2 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_o[0]), .gnt_id(id_o[0]), .valid(vld_o[0]), .expire(exp_o[0]));
  arb4_ctrl #(.MAX_HOLD(8), .HOLD_W(4)) u_h8 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_o[1]), .gnt_id(id_o[1]), .valid(vld_o[1]), .expire(exp_o[1]));
  arb4_ctrl #(.MAX_HOLD(0), .HOLD_W(4)) u_h0 (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode),
    .gnt(gnt_o[2]), .gnt_id(id_o[2]), .valid(vld_o[2]), .expire(exp_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner (-1 = none), cycles granted so far, last grantee, expire pulse.
  int own  [3];
  int ten  [3];
  int last [3];
  bit mexp [3];

  function automatic int pick(logic [3:0] r, int base);
    for (int k = 1; k <= 4; k++) begin
      int id;
      id = (base - k + 8) % 4;
      if (r[id]) return id;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        own[i] = -1; ten[i] = 0; last[i] = 0; mexp[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (own[i] < 0) begin
          int w;
          mexp[i] = 1'b0;
          w = pick(req, (mode == 1'b1) ? last[i] : 0);
          if (w >= 0) begin
            own[i] = w; ten[i] = 1; last[i] = w;
          end
        end else if (!req[own[i]]) begin
          own[i] = -1; mexp[i] = 1'b0;
        end else if (MH[i] != 0 && ten[i] == MH[i]) begin
          own[i] = -1; mexp[i] = 1'b1;
        end else begin
          ten[i] = ten[i] + 1; mexp[i] = 1'b0;
        end
      end
    end
  end

  task automatic check();
    for (int i = 0; i < 3; i++) begin
      logic [3:0] eg;
      logic [1:0] ei;
      logic       ev;
      eg = (own[i] < 0) ? 4'b0000 : 4'(1 << own[i]);
      ei = (own[i] < 0) ? 2'd0 : 2'(own[i]);
      ev = (own[i] >= 0);
      n_cmp++;
      assert (gnt_o[i] === eg) else begin
        n_err++; $error("FAIL model_gnt[%0d] got %b want %b", i, gnt_o[i], eg);
      end
      n_cmp++;
      assert (id_o[i] === ei) else begin
        n_err++; $error("FAIL model_gnt_id[%0d] got %0d want %0d", i, id_o[i], ei);
      end
      n_cmp++;
      assert (vld_o[i] === ev) else begin
        n_err++; $error("FAIL model_valid[%0d] got %b want %b", i, vld_o[i], ev);
      end
      n_cmp++;
      assert (exp_o[i] === mexp[i]) else begin
        n_err++; $error("FAIL model_expire[%0d] got %b want %b", i, exp_o[i], mexp[i]);
      end
    end
  endtask

  task automatic expect4(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++; $error("FAIL %s got %b want %b", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic do_reset(input logic m);
    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = m;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int nv;
    int nx;
    int q [$];
    logic pv;

    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    #1;
    expect4("reset_gnt", gnt_o[1], 4'b0000);
    expect4("reset_id", {2'b00, id_o[1]}, 4'b0000);
    expect4("reset_valid", {3'b000, vld_o[1]}, 4'b0000);
    expect4("reset_expire", {3'b000, exp_o[1]}, 4'b0000);
    do_reset(1'b0);

    // Fixed priority: 0110 -> 2, drop req[2] -> idle, then 1.
    req = 4'b0110;
    tick();
    expect4("fixed_gnt", gnt_o[1], 4'b0100);
    expect4("fixed_id", {2'b00, id_o[1]}, 4'd2);
    req = 4'b0010;
    tick();
    expect4("fixed_release", gnt_o[1], 4'b0000);
    tick();
    expect4("fixed_next", gnt_o[1], 4'b0010);
    req = 4'b0000;
    tick();
    tick();

    // Round-robin fairness with hold limit 2.
    do_reset(1'b1);
    req = 4'b1111;
    nv = 0; nx = 0; pv = 1'b0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (vld_o[0] && !pv) q.push_back(int'(id_o[0]));
      if (vld_o[0]) nv++;
      if (exp_o[0]) nx++;
      pv = vld_o[0];
    end
    expect4("rr_grants", 4'(q.size()), 4'd5);
    if (q.size() >= 5) begin
      expect4("rr_seq0", 4'(q[0]), 4'd3);
      expect4("rr_seq1", 4'(q[1]), 4'd2);
      expect4("rr_seq2", 4'(q[2]), 4'd1);
      expect4("rr_seq3", 4'(q[3]), 4'd0);
      expect4("rr_seq4", 4'(q[4]), 4'd3);
    end
    expect4("rr_busy_cycles", 4'(nv), 4'd10);
    expect4("rr_expires", 4'(nx), 4'd5);

    // Hold limit 8: high 8 cycles, idle with expire, re-grant.
    do_reset(1'b0);
    req = 4'b0010;
    for (int t = 1; t <= 20; t++) begin
      tick();
      expect4("hold8_gnt", gnt_o[1], ((t % 9) != 0) ? 4'b0010 : 4'b0000);
      expect4("hold8_expire", {3'b000, exp_o[1]}, ((t % 9) == 0) ? 4'd1 : 4'd0);
    end

    // Unlimited hold.
    do_reset(1'b0);
    req = 4'b0001;
    for (int t = 0; t < 50; t++) begin
      tick();
      expect4("unlim_gnt", gnt_o[2], 4'b0001);
      expect4("unlim_expire", {3'b000, exp_o[2]}, 4'b0000);
    end

    // Asynchronous reset during a grant to id 2, then RR restarts at ptr 0.
    do_reset(1'b0);
    req = 4'b0100;
    tick();
    expect4("pre_rst_gnt", gnt_o[1], 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    expect4("async_rst_gnt", gnt_o[1], 4'b0000);
    expect4("async_rst_valid", {3'b000, vld_o[1]}, 4'b0000);
    expect4("async_rst_id", {2'b00, id_o[1]}, 4'b0000);
    check();
    #2;
    mode  = 1'b1;
    req   = 4'b1001;
    rst_n = 1'b1;
    tick();
    expect4("post_rst_rr", gnt_o[1], 4'b1000);
    req = 4'b0000;
    tick();

    // Late requester during a tenure is ignored until release.
    do_reset(1'b0);
    req = 4'b0001;
    tick();
    tick();
    req = 4'b1001;
    tick();
    expect4("late_hold0", gnt_o[2], 4'b0001);
    tick();
    expect4("late_hold1", gnt_o[2], 4'b0001);
    req = 4'b1000;
    tick();
    expect4("late_idle", gnt_o[2], 4'b0000);
    tick();
    expect4("late_gnt3", gnt_o[2], 4'b1000);

    // Randomized traffic against the model, with occasional mid-cycle resets.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      if ($urandom_range(0, 63) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check();
        #2 rst_n = 1'b1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
